fetch_queue: RTL and testbench
==============================

# fetch_queue

Owns the program counter and a 2-entry instruction queue between the combinational fetch stage and decode. Each cycle it drives the current word address to fetch, captures the returned instruction and incremented PC into the queue, and presents the oldest entry to decode through a valid/ready handshake. A redirect from a resolved branch or jump flushes the queue and reloads the PC.

## Interface

Parameters:

- RESET_PC, 30'h0000_0000, word address loaded into the PC on reset.

Ports:

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- pc  out  30  current fetch word address (byte address = {pc, 2'b00}); drives fetch.
- fetch_instr  in  32  instruction returned combinationally for `pc`.
- fetch_pc_plus1  in  30  `pc + 1` from fetch, modulo 2^30.
- redirect_valid  in  1  resolved taken branch or jump.
- redirect_pc  in  30  target word address, sampled when redirect_valid=1.
- id_ready  in  1  decode accepts the head entry this cycle.
- id_valid  out  1  head entry present.
- id_instr  out  32  head instruction.
- id_pc  out  30  word address of the head instruction.
- id_pc_plus1  out  30  id_pc + 1, carried from fetch.
- q_count  out  2  occupancy, 0..2.

## Operation

- Storage: 2 entries of {instr[31:0], pc[29:0], pc_plus1[29:0]}, plus 1-bit rd_ptr, 1-bit wr_ptr, 2-bit count. Pointers wrap 1->0.
- pop = id_valid & id_ready.
- push = ~redirect_valid & ((count != 2) | pop). Fetch continues into a full queue only when the head leaves in the same cycle.
- Push writes {fetch_instr, pc, fetch_pc_plus1} at wr_ptr and advances wr_ptr. Pop advances rd_ptr.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- PC update, in priority order:
  - reset: pc <= RESET_PC.
  - redirect_valid: pc <= redirect_pc.
  - push: pc <= fetch_pc_plus1.
  - otherwise pc holds.
- Redirect:
  - count, rd_ptr and wr_ptr go to 0.
  - The instruction fetched in the redirect cycle is discarded.
  - A pop in the redirect cycle still counts as consumed by decode.
  - All other queued entries are dropped.
- Outputs: id_valid = (count != 0). id_instr, id_pc and id_pc_plus1 are read from entry[rd_ptr]; they are don't-care when id_valid=0 and must not contain X once written. q_count = count.
- Wrap-around:
  - pc 30'h3FFF_FFFF followed by pc_plus1 0 is legal; pc becomes 0.
  - No sign or carry handling is done here.
- Reset values: pc=RESET_PC, id_valid=0, q_count=0, rd_ptr=wr_ptr=0. Entry contents are unspecified, but reset clears them to 0 for clean waveforms.
- Reset mid-operation overrides redirect, push and pop in the same cycle.

## Timing

- Empty queue, no stall: the instruction at pc in cycle N appears on the id_* outputs in cycle N+1 with id_valid=1. Steady-state throughput is 1 instruction per cycle.
- Redirect asserted in cycle N:
  - cycle N+1: pc=redirect_pc, id_valid=0.
  - cycle N+2: target instruction on id_*.
  - Redirect penalty is 1 bubble.
- After reset deassertion in cycle N: pc=RESET_PC in cycle N+1, first id_valid=1 in cycle N+2.
- id_ready held low:
  - The queue fills in 2 cycles and pc freezes on the third instruction's address.
  - When id_ready rises, the queue drains in order with no duplicates and no skipped PCs.
- id_* outputs change only on clock edges. No combinational path from id_ready to id_valid or id_instr. The only combinational path is id_ready -> pc-advance enable.

## Test plan

- Reset with RESET_PC=0, memory word0=0x00832820, word1=0x34660004, id_ready=1 -> cycle after release: pc=0. Next: id_valid=1, id_instr=0x00832820, id_pc=0, id_pc_plus1=1. Next: id_instr=0x34660004, id_pc=1.
- id_ready=0 for 4 cycles from pc=0 -> q_count 1 then 2, pc holds at 2. Raise id_ready -> id_pc sequence 0,1,2,3 with no gaps and q_count stays 2 while draining.
- redirect_valid=1, redirect_pc=30'h10 with q_count=2 -> next cycle: id_valid=0, q_count=0, pc=0x10. Cycle after: id_pc=0x10.
- redirect_valid and pop in the same cycle with q_count=1 -> popped entry is consumed once, no entry survives, pc=redirect_pc.
- pc=30'h3FFF_FFFF, fetch_pc_plus1=0, queue not full -> next cycle pc=0, and the queued entry has id_pc=30'h3FFF_FFFF, id_pc_plus1=0.
- reset asserted while q_count=2 and redirect_valid=1 -> next cycle: pc=RESET_PC, id_valid=0, q_count=0. Reset wins over redirect.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch/decode-side signal bundle for fetch_queue.
// The slave modport is the queue; the master modport is the surrounding fetch and decode logic.
interface fetch_queue_if;
  localparam int unsigned PC_W    = 30;
  localparam int unsigned INSTR_W = 32;

  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] fetch_instr;
  logic [PC_W-1:0]    fetch_pc_plus1;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               id_ready;
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [PC_W-1:0]    id_pc;
  logic [PC_W-1:0]    id_pc_plus1;
  logic [1:0]         q_count;

  modport master (
    output fetch_instr, fetch_pc_plus1, redirect_valid, redirect_pc, id_ready,
    input  pc, id_valid, id_instr, id_pc, id_pc_plus1, q_count
  );

  modport slave (
    input  fetch_instr, fetch_pc_plus1, redirect_valid, redirect_pc, id_ready,
    output pc, id_valid, id_instr, id_pc, id_pc_plus1, q_count
  );
endinterface

// File: rtl/fetch_queue.sv
// Program counter plus a 2-entry instruction queue between fetch and decode.
// A redirect flushes the queue, discards the in-flight fetch and reloads the PC.
module fetch_queue #(
  parameter logic [29:0] RESET_PC = 30'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  bus
);

  localparam int unsigned PC_W    = 30;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned DEPTH   = 2;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus1;
  } entry_t;

  logic [PC_W-1:0] r_pc;
  entry_t          r_entry [DEPTH];
  logic            r_rd_ptr;
  logic            r_wr_ptr;
  logic [1:0]      r_count;

  logic   w_pop;
  logic   w_push;
  logic   w_full;
  entry_t w_head;
  entry_t w_new;

  // A full queue still accepts a fetch when the head drains in the same cycle.
  assign w_full = (r_count == 2'(DEPTH));
  assign w_pop  = (r_count != 2'd0) & bus.id_ready;
  assign w_push = ~bus.redirect_valid & (~w_full | w_pop);

  assign w_new.instr    = bus.fetch_instr;
  assign w_new.pc       = r_pc;
  assign w_new.pc_plus1 = bus.fetch_pc_plus1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_entry[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      r_pc     <= bus.redirect_pc;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_entry[r_wr_ptr] <= w_new;
        r_wr_ptr          <= ~r_wr_ptr;
        r_pc              <= bus.fetch_pc_plus1;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 2'd1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

  // Decode sees only registered state: no id_ready -> id_* path.
  assign w_head          = r_entry[r_rd_ptr];
  assign bus.pc          = r_pc;
  assign bus.id_valid    = (r_count != 2'd0);
  assign bus.id_instr    = w_head.instr;
  assign bus.id_pc       = w_head.pc;
  assign bus.id_pc_plus1 = w_head.pc_plus1;
  assign bus.q_count     = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_fetch_queue;

  localparam logic [29:0] RST_PC = 30'h0000_0000;

  logic clk;
  logic reset;
  fetch_queue_if bus ();

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [29:0] pc;
    logic [29:0] pc1;
  } m_entry_t;

  m_entry_t    mq[$];
  logic [29:0] mpc;

  fetch_queue #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    if (a == 30'd0) return 32'h0083_2820;
    if (a == 30'd1) return 32'h3466_0004;
    return {a, 2'b11} ^ 32'h5A5A_1234;
  endfunction

  // Combinational instruction memory seen by the fetch stage.
  assign bus.fetch_instr    = mem_word(bus.pc);
  assign bus.fetch_pc_plus1 = bus.pc + 30'd1;

  // One clock: drive inputs, advance the reference model at the edge, settle.
  task automatic tick(input logic rdy, input logic rv, input logic [29:0] rpc, input logic rst);
    logic pop, push;
    m_entry_t e;
    bus.id_ready       = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    reset              = rst;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mpc = RST_PC;
    end else begin
      pop  = (mq.size() != 0) && rdy;
      push = !rv && ((mq.size() < 2) || pop);
      if (rv) begin
        mq.delete();
        mpc = rpc;
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) begin
          e.instr = mem_word(mpc);
          e.pc    = mpc;
          e.pc1   = mpc + 30'd1;
          mq.push_back(e);
          mpc = mpc + 30'd1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 30'd0, 1'b1);
    tick(1'b1, 1'b0, 30'd0, 1'b1);
    n_checks++; if (bus.pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h exp %h", bus.pc, RST_PC); end
    n_checks++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", bus.id_valid); end
    n_checks++; if (bus.q_count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", bus.q_count); end
    tick(1'b1, 1'b0, 30'd0, 1'b0);
    n_checks++; if (bus.id_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b exp 1", bus.id_valid); end
    n_checks++; if (bus.id_instr !== 32'h0083_2820) begin n_fail++; $display("FAIL first_instr: got %h exp 00832820", bus.id_instr); end
    n_checks++; if ({bus.id_pc, bus.id_pc_plus1} !== {30'd0, 30'd1}) begin n_fail++; $display("FAIL first_pcs: got %h/%h exp 0/1", bus.id_pc, bus.id_pc_plus1); end
    tick(1'b1, 1'b0, 30'd0, 1'b0);
    n_checks++; if ({bus.id_instr, bus.id_pc} !== {32'h3466_0004, 30'd1}) begin n_fail++; $display("FAIL second_entry: got %h@%h exp 34660004@1", bus.id_instr, bus.id_pc); end
  endtask

  task automatic test_stall();
    logic [1:0] exp_cnt [4] = '{2'd1, 2'd2, 2'd2, 2'd2};
    logic [29:0] exp_pc [3] = '{30'd1, 30'd2, 30'd3};
    tick(1'b0, 1'b0, 30'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 30'd0, 1'b0);
      n_checks++; if (bus.q_count !== exp_cnt[i]) begin n_fail++; $display("FAIL stall_count[%0d]: got %0d exp %0d", i, bus.q_count, exp_cnt[i]); end
    end
    n_checks++; if (bus.pc !== 30'd2) begin n_fail++; $display("FAIL stall_pc_hold: got %h exp 2", bus.pc); end
    n_checks++; if (bus.id_pc !== 30'd0) begin n_fail++; $display("FAIL stall_head: got %h exp 0", bus.id_pc); end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 30'd0, 1'b0);
      n_checks++; if ({bus.id_valid, bus.id_pc, bus.q_count} !== {1'b1, exp_pc[i], 2'd2}) begin
        n_fail++; $display("FAIL drain[%0d]: got v=%b pc=%h cnt=%0d exp v=1 pc=%h cnt=2", i, bus.id_valid, bus.id_pc, bus.q_count, exp_pc[i]);
      end
    end
  endtask

  task automatic test_redirect();
    tick(1'b0, 1'b0, 30'd0, 1'b0);
    n_checks++; if (bus.q_count !== 2'd2) begin n_fail++; $display("FAIL redir_setup: got %0d exp 2", bus.q_count); end
    tick(1'b0, 1'b1, 30'h10, 1'b0);
    n_checks++; if ({bus.id_valid, bus.q_count, bus.pc} !== {1'b0, 2'd0, 30'h10}) begin
      n_fail++; $display("FAIL redir_flush: got v=%b cnt=%0d pc=%h exp v=0 cnt=0 pc=10", bus.id_valid, bus.q_count, bus.pc);
    end
    tick(1'b1, 1'b0, 30'd0, 1'b0);
    n_checks++; if ({bus.id_valid, bus.id_pc, bus.id_instr} !== {1'b1, 30'h10, mem_word(30'h10)}) begin
      n_fail++; $display("FAIL redir_target: got v=%b pc=%h instr=%h exp v=1 pc=10 instr=%h", bus.id_valid, bus.id_pc, bus.id_instr, mem_word(30'h10));
    end
  endtask

  task automatic test_redirect_pop();
    tick(1'b0, 1'b0, 30'd0, 1'b1);
    tick(1'b0, 1'b0, 30'd0, 1'b0);
    n_checks++; if ({bus.q_count, bus.id_pc} !== {2'd1, 30'd0}) begin n_fail++; $display("FAIL rp_setup: got cnt=%0d pc=%h exp cnt=1 pc=0", bus.q_count, bus.id_pc); end
    tick(1'b1, 1'b1, 30'h20, 1'b0);
    n_checks++; if ({bus.id_valid, bus.q_count, bus.pc} !== {1'b0, 2'd0, 30'h20}) begin
      n_fail++; $display("FAIL rp_flush: got v=%b cnt=%0d pc=%h exp v=0 cnt=0 pc=20", bus.id_valid, bus.q_count, bus.pc);
    end
    tick(1'b0, 1'b0, 30'd0, 1'b0);
    tick(1'b0, 1'b0, 30'd0, 1'b0);
    n_checks++; if ({bus.q_count, bus.id_pc, bus.pc} !== {2'd2, 30'h20, 30'h22}) begin
      n_fail++; $display("FAIL rp_after: got cnt=%0d head=%h pc=%h exp cnt=2 head=20 pc=22", bus.q_count, bus.id_pc, bus.pc);
    end
  endtask

  task automatic test_wrap();
    tick(1'b1, 1'b1, 30'h3FFF_FFFF, 1'b0);
    n_checks++; if (bus.pc !== 30'h3FFF_FFFF) begin n_fail++; $display("FAIL wrap_load: got %h exp 3fffffff", bus.pc); end
    tick(1'b0, 1'b0, 30'd0, 1'b0);
    n_checks++; if ({bus.pc, bus.id_pc, bus.id_pc_plus1, bus.q_count} !== {30'd0, 30'h3FFF_FFFF, 30'd0, 2'd1}) begin
      n_fail++; $display("FAIL wrap_entry: got pc=%h head=%h p1=%h cnt=%0d exp pc=0 head=3fffffff p1=0 cnt=1", bus.pc, bus.id_pc, bus.id_pc_plus1, bus.q_count);
    end
  endtask

  task automatic test_reset_override();
    tick(1'b0, 1'b0, 30'd0, 1'b0);
    n_checks++; if (bus.q_count !== 2'd2) begin n_fail++; $display("FAIL ro_setup: got %0d exp 2", bus.q_count); end
    tick(1'b1, 1'b1, 30'h55, 1'b1);
    n_checks++; if ({bus.pc, bus.id_valid, bus.q_count} !== {RST_PC, 1'b0, 2'd0}) begin
      n_fail++; $display("FAIL reset_over_redirect: got pc=%h v=%b cnt=%0d exp pc=%h v=0 cnt=0", bus.pc, bus.id_valid, bus.q_count, RST_PC);
    end
  endtask

  task automatic test_random();
    logic rdy, rv, rst;
    logic [29:0] rpc;
    m_entry_t h;
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(0, 99) < 65);
      rv  = ($urandom_range(0, 99) < 10);
      rst = ($urandom_range(0, 99) < 2);
      rpc = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFE : 30'($urandom);
      tick(rdy, rv, rpc, rst);
      n_checks++; if ({bus.pc, bus.id_valid, bus.q_count} !== {mpc, mq.size() != 0, 2'(mq.size())}) begin
        n_fail++; $display("FAIL rand_state c=%0d: got pc=%h v=%b cnt=%0d exp pc=%h v=%b cnt=%0d",
                           c, bus.pc, bus.id_valid, bus.q_count, mpc, mq.size() != 0, mq.size());
      end
      if (mq.size() != 0) begin
        h = mq[0];
        n_checks++; if ({bus.id_instr, bus.id_pc, bus.id_pc_plus1} !== {h.instr, h.pc, h.pc1}) begin
          n_fail++; $display("FAIL rand_head c=%0d: got %h@%h/%h exp %h@%h/%h",
                             c, bus.id_instr, bus.id_pc, bus.id_pc_plus1, h.instr, h.pc, h.pc1);
        end
      end
    end
  endtask

  initial begin
    reset              = 1'b1;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 30'd0;
    mpc                = RST_PC;
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_reset_override();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
